alu_ctrl: RTL and testbench

- Command-side sequencer that drives the 16-bit accumulator ALU's control interface: opcode, operand bus, read/write/writeu strobes, plus accout/flag readback.
- Accepts one decoded command per valid/ready handshake and expands it into the required ALU strobe sequence.
- Returns accumulator/flag results on a valid/ready response channel.
- Sits between the instruction decoder and the ALU; it is the only master of the ALU control pins.

---
 rtl/alu_ctrl.sv | 137 +++++++++++++
 tb/tb_alu_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl.sv
// Command sequencer for the 16-bit accumulator ALU: expands one decoded command
// into the ALU strobe sequence and returns accumulator/flag readback.
module alu_ctrl #(
  parameter bit         CLEAR_ON_RESET = 1'b1,
  parameter logic [4:0] NOP_CODE       = 5'b00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_kind,
  input  logic [4:0]  cmd_aluop,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_flag,
  output logic [4:0]  alu_opcode,
  output logic [15:0] alu_operand,
  output logic        alu_read,
  output logic        alu_write,
  output logic        alu_writeu,
  input  logic [15:0] alu_accout,
  input  logic        alu_flag
);

  typedef enum logic [2:0] {
    K_NOP, K_LD, K_LDU, K_LDW, K_EXEC, K_READ, K_EXRD, K_FLAG
  } kind_t;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_LDLO, S_LDHI, S_EXEC, S_READ, S_RESP
  } state_t;

  state_t      state, state_nxt;
  logic        started;
  kind_t       kind_q;
  logic [4:0]  aluop_q;
  logic [15:0] data_q;
  logic        accept;

  // started stays low for the first cycle after reset release so the
  // optional clear can be issued before any command is taken.
  assign cmd_ready = (state == S_IDLE) && started;
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_valid = (state == S_RESP);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      started <= 1'b0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_q  <= K_NOP;
      aluop_q <= '0;
      data_q  <= '0;
    end else if (accept) begin
      kind_q  <= kind_t'(cmd_kind);
      aluop_q <= cmd_aluop;
      data_q  <= cmd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_flag <= 1'b0;
    end else if (state == S_READ) begin
      rsp_data <= (kind_q == K_FLAG) ? 16'h0000 : alu_accout;
      rsp_flag <= alu_flag;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (!started) begin
          state_nxt = CLEAR_ON_RESET ? S_INIT : S_IDLE;
        end else if (accept) begin
          unique case (kind_t'(cmd_kind))
            K_NOP:          state_nxt = S_IDLE;
            K_LD, K_LDW:    state_nxt = S_LDLO;
            K_LDU:          state_nxt = S_LDHI;
            K_EXEC, K_EXRD: state_nxt = S_EXEC;
            K_READ, K_FLAG: state_nxt = S_READ;
            default:        state_nxt = S_IDLE;
          endcase
        end
      end
      S_INIT:  state_nxt = S_IDLE;
      S_LDLO:  state_nxt = (kind_q == K_LDW) ? S_LDHI : S_IDLE;
      S_LDHI:  state_nxt = S_IDLE;
      S_EXEC:  state_nxt = (kind_q == K_EXRD) ? S_READ : S_IDLE;
      S_READ:  state_nxt = S_RESP;
      S_RESP:  state_nxt = rsp_ready ? S_IDLE : S_RESP;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ALU pins decode only state and the latched command, never live inputs.
  always_comb begin
    alu_opcode  = NOP_CODE;
    alu_operand = 16'h0000;
    alu_read    = 1'b0;
    alu_write   = 1'b0;
    alu_writeu  = 1'b0;
    unique case (state)
      S_INIT: alu_write = 1'b1;
      S_LDLO: begin
        alu_write   = 1'b1;
        alu_operand = (kind_q == K_LDW) ? {4'h0, data_q[11:0]} : data_q;
      end
      S_LDHI: begin
        alu_writeu  = 1'b1;
        alu_operand = {12'h000, data_q[15:12]};
      end
      S_EXEC: begin
        alu_opcode  = aluop_q;
        alu_operand = data_q;
      end
      S_READ:  alu_read = (kind_q != K_FLAG);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl: a stand-in ALU on the control pins, a
// command-level accumulator/flag model feeding an expected-response queue.
module tb_alu_ctrl;

  localparam logic [4:0] NOP     = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_CE   = 5'b01100;
  localparam logic [4:0] OP_NOTF = 5'b10000;

  localparam logic [2:0] K_NOP = 3'd0, K_LD = 3'd1, K_LDU = 3'd2, K_LDW = 3'd3,
                         K_EXEC = 3'd4, K_READ = 3'd5, K_EXRD = 3'd6, K_FLAG = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_kind;
  logic [4:0]  cmd_aluop;
  logic [15:0] cmd_data;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_flag;
  logic [4:0]  alu_opcode;
  logic [15:0] alu_operand;
  logic        alu_read, alu_write, alu_writeu;
  logic [15:0] alu_accout;
  logic        alu_flag;

  always #5 clk = ~clk;

  alu_ctrl #(.CLEAR_ON_RESET(1'b1), .NOP_CODE(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
    .cmd_aluop(cmd_aluop), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_flag(rsp_flag),
    .alu_opcode(alu_opcode), .alu_operand(alu_operand), .alu_read(alu_read),
    .alu_write(alu_write), .alu_writeu(alu_writeu),
    .alu_accout(alu_accout), .alu_flag(alu_flag)
  );

  // Stand-in accumulator ALU; it is not reset by rst_n, only by the clear write.
  logic [15:0] alu_acc = 16'h0000;
  logic        alu_f   = 1'b0;
  assign alu_accout = alu_acc;
  assign alu_flag   = alu_f;

  always @(posedge clk) begin
    if (alu_write)       alu_acc <= alu_operand;
    else if (alu_writeu) alu_acc[15:12] <= alu_operand[3:0];
    else begin
      case (alu_opcode)
        OP_ADD:  alu_acc <= alu_acc + alu_operand;
        OP_CE:   alu_f   <= (alu_acc == alu_operand);
        OP_NOTF: alu_f   <= ~alu_f;
        default: ;
      endcase
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Command-level model: what the accumulator and flag must hold after each command.
  logic [15:0] m_acc = 16'h0000;
  logic        m_flag = 1'b0;
  logic [16:0] exp_q[$];

  task automatic model_op(input logic [4:0] op, input logic [15:0] d);
    if (op == OP_ADD)       m_acc  = m_acc + d;
    else if (op == OP_CE)   m_flag = (m_acc == d);
    else if (op == OP_NOTF) m_flag = !m_flag;
  endtask

  task automatic model_cmd(input logic [2:0] kind, input logic [4:0] op, input logic [15:0] d);
    case (kind)
      K_LD, K_LDW: m_acc = d;
      K_LDU:       m_acc[15:12] = d[15:12];
      K_EXEC:      model_op(op, d);
      K_READ:      exp_q.push_back({m_flag, m_acc});
      K_EXRD: begin
        model_op(op, d);
        exp_q.push_back({m_flag, m_acc});
      end
      K_FLAG:      exp_q.push_back({m_flag, 16'h0000});
      default: ;
    endcase
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic issue(input logic [2:0] kind, input logic [4:0] op, input logic [15:0] d);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_kind  = kind;
    cmd_aluop = op;
    cmd_data  = d;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept_wait", 32'(n < 20), 32'd1);
    if (n < 20) model_cmd(kind, op, d);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Per-cycle compare: pin exclusivity, response hold-stability, response payload.
  logic        hold_v = 1'b0;
  logic [16:0] hold_d = '0;

  always begin
    @(negedge clk);
    #1;
    if (rst_n !== 1'b1) begin
      hold_v = 1'b0;
    end else begin
      check("excl_write_writeu", 32'(alu_write & alu_writeu), 32'd0);
      check("excl_write_opcode", 32'((alu_write | alu_writeu) && alu_opcode != NOP), 32'd0);
      if (hold_v) begin
        check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
        check("rsp_hold_data", 32'({rsp_flag, rsp_data}), 32'(hold_d));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected: got 0x%0h expected no response", {rsp_flag, rsp_data});
        end else begin
          check("rsp_payload", 32'({rsp_flag, rsp_data}), 32'(exp_q.pop_front()));
        end
      end
      hold_v = rsp_valid && !rsp_ready;
      hold_d = {rsp_flag, rsp_data};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached without finishing", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_kind = K_NOP; cmd_aluop = NOP; cmd_data = 16'h0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'({rsp_flag, rsp_data}), 32'd0);
    check("rst_strobes", 32'({alu_read, alu_write, alu_writeu}), 32'd0);
    check("rst_opcode", 32'(alu_opcode), 32'(NOP));

    rst_n = 1'b1;
    check("release_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("init_write", 32'(alu_write), 32'd1);
    check("init_operand", 32'(alu_operand), 32'h0000);
    check("init_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("post_init_ready", 32'(cmd_ready), 32'd1);
    check("post_init_write", 32'(alu_write), 32'd0);

    // READ after clear
    issue(K_READ, NOP, 16'h5555);
    check("rd_alu_read", 32'(alu_read), 32'd1);
    check("rd_t1_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("rd_t2_valid", 32'(rsp_valid), 32'd1);
    check("rd_t2_data", 32'(rsp_data), 32'h0000);
    @(negedge clk);
    check("rd_next_ready", 32'(cmd_ready), 32'd1);

    // LD then EXRD ADD
    issue(K_LD, NOP, 16'h1234);
    check("ld_write", 32'(alu_write), 32'd1);
    check("ld_operand", 32'(alu_operand), 32'h1234);
    issue(K_EXRD, OP_ADD, 16'h0001);
    check("exrd_opcode", 32'(alu_opcode), 32'(OP_ADD));
    check("exrd_operand", 32'(alu_operand), 32'h0001);
    check("exrd_no_write", 32'({alu_write, alu_writeu, alu_read}), 32'd0);
    @(negedge clk);
    check("exrd_read", 32'(alu_read), 32'd1);
    check("exrd_t2_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("exrd_t3_valid", 32'(rsp_valid), 32'd1);
    check("exrd_data", 32'(rsp_data), 32'h1235);
    @(negedge clk);

    // LDW split into low and high writes
    issue(K_LDW, NOP, 16'hABCD);
    check("ldw_lo_write", 32'({alu_write, alu_writeu}), 32'b10);
    check("ldw_lo_operand", 32'(alu_operand), 32'h0BCD);
    check("ldw_lo_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("ldw_hi_writeu", 32'({alu_write, alu_writeu}), 32'b01);
    check("ldw_hi_operand", 32'(alu_operand), 32'h000A);
    @(negedge clk);
    check("ldw_done_ready", 32'(cmd_ready), 32'd1);
    issue(K_READ, NOP, 16'h0000);
    @(negedge clk);
    check("ldw_readback", 32'(rsp_data), 32'hABCD);
    @(negedge clk);

    // Compare-equal then FLAG, NOTF then FLAG
    issue(K_LD, NOP, 16'h0005);
    issue(K_EXEC, OP_CE, 16'h0005);
    check("ce_opcode", 32'(alu_opcode), 32'(OP_CE));
    @(negedge clk);
    check("exec_done_ready", 32'(cmd_ready), 32'd1);
    issue(K_FLAG, NOP, 16'hFFFF);
    check("flag_no_read", 32'(alu_read), 32'd0);
    @(negedge clk);
    check("flag_valid", 32'(rsp_valid), 32'd1);
    check("flag_ce", 32'({rsp_flag, rsp_data}), 32'h1_0000);
    @(negedge clk);
    issue(K_EXEC, OP_NOTF, 16'h0000);
    issue(K_FLAG, NOP, 16'h0000);
    @(negedge clk);
    check("flag_notf", 32'({rsp_flag, rsp_data}), 32'h0_0000);
    @(negedge clk);

    // Response back-pressure
    rsp_ready = 1'b0;
    issue(K_READ, NOP, 16'h0000);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data", 32'(rsp_data), 32'h0005);
      check("bp_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_after_ready", 32'(cmd_ready), 32'd1);

    // LDU replaces only the top nibble; NOP leaves the ALU alone
    issue(K_LDU, NOP, 16'h7000);
    check("ldu_writeu", 32'({alu_write, alu_writeu}), 32'b01);
    check("ldu_operand", 32'(alu_operand), 32'h0007);
    issue(K_READ, NOP, 16'h0000);
    @(negedge clk);
    check("ldu_readback", 32'(rsp_data), 32'h7005);
    @(negedge clk);
    issue(K_NOP, OP_ADD, 16'h1111);
    check("nop_ready", 32'(cmd_ready), 32'd1);
    check("nop_strobes", 32'({alu_read, alu_write, alu_writeu}), 32'd0);
    check("nop_opcode", 32'(alu_opcode), 32'(NOP));

    // Reset in the middle of LDW
    issue(K_LDW, NOP, 16'hABCD);
    @(negedge clk);
    check("mid_ldhi_writeu", 32'(alu_writeu), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_writeu", 32'({alu_write, alu_writeu}), 32'd0);
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd0);
    check("mid_rst_opcode", 32'(alu_opcode), 32'(NOP));
    m_acc = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_init_write", 32'(alu_write), 32'd1);
    @(negedge clk);
    issue(K_READ, NOP, 16'h0000);
    @(negedge clk);
    check("mid_readback", 32'(rsp_data), 32'h0000);

    repeat (3) @(negedge clk);
    check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
